// File: rtl/shift_exec_pkg.sv
// Shared types and helpers for the shift execute stage: decoded op encoding,
// funct3 constants and the shift-amount width for a given XLEN.
package shift_exec_pkg;

   typedef enum logic [1:0] {
      OP_SLL = 2'd0,
      OP_SRL = 2'd1,
      OP_SRA = 2'd2,
      OP_ILL = 2'd3
   } op_e;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

   function automatic int shamt_width(input int xlen);
      if (xlen >= 128)
         return 7;
      else if (xlen >= 64)
         return 6;
      else
         return 5;
   endfunction

endpackage

// File: rtl/shift.sv
// Existing combinational log-stage barrel shifter; LEFT selects direction and
// arith requests sign fill on right shifts.
module Shift
   import shift_exec_pkg::*;
#(
   parameter int XLEN = 32,
   parameter bit LEFT = 1'b1
) (
   input  logic [XLEN-1:0]              a,
   input  logic [shamt_width(XLEN)-1:0] shamt,
   input  logic                         arith,
   output logic [XLEN-1:0]              result
);
   localparam int SHW = shamt_width(XLEN);

   logic [XLEN-1:0] stage;
   logic            fill;

   // Each shamt bit enables one power-of-two stage; right shifts OR in the
   // sign bits over the vacated positions when fill is requested.
   always_comb begin
      stage = a;
      fill  = !LEFT && arith && a[XLEN-1];
      for (int i = 0; i < SHW; i++) begin
         if (shamt[i]) begin
            if (LEFT)
               stage = stage << (1 << i);
            else
               stage = (stage >> (1 << i)) |
                       (fill ? ~({XLEN{1'b1}} >> (1 << i)) : '0);
         end
      end
      result = stage;
   end

endmodule

// File: rtl/shift_exec_stage_word_adjust.sv
// W-variant conditioning: 32-bit operand extension before the shift and
// sign extension of the low word after it. Only built with SHIFT_EXEC_WORD_OPS_EN.
module shift_word_adjust #(
   parameter int XLEN = 64
) (
   input  logic            word,
   input  logic            sra,
   input  logic [XLEN-1:0] a,
   output logic [XLEN-1:0] operand,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] result
);
   if (XLEN < 64) begin : g_bad_xlen
      $error("shift_word_adjust: word ops need XLEN >= 64");
   end

   always_comb begin
      operand = a;
      result  = raw;
      if (word) begin
         operand = sra ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0]);
         result  = XLEN'($signed(raw[31:0]));
      end
   end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift execute unit with valid/ready on both sides.
// Optional W-variant support is enabled by defining SHIFT_EXEC_WORD_OPS_EN.
module shift_exec_stage
   import shift_exec_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_funct3,
   input  logic             in_funct7b5,
   input  logic             in_word,
   input  logic [XLEN-1:0]  in_a,
   input  logic [XLEN-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);
   localparam int SHW = shamt_width(XLEN);
   localparam logic [SHW-1:0] WORD_MASK = SHW'(31);

   if (XLEN != 32 && XLEN != 64 && XLEN != 128) begin : g_bad_xlen
      $error("shift_exec_stage: XLEN must be 32, 64 or 128");
   end

   op_e             dec_op;
   logic [SHW-1:0]  dec_shamt;
   logic            s1_valid;
   logic            s2_valid;
   op_e             s1_op;
   logic [XLEN-1:0] s1_a;
   logic [SHW-1:0]  s1_shamt;
   logic [TAG_W-1:0] s1_tag;
   logic            s1_adv;
   logic            s2_adv;
   logic [XLEN-1:0] sh_in;
   logic [XLEN-1:0] sh_raw;
   logic [XLEN-1:0] sh_out;
   logic [XLEN-1:0] left_res;
   logic [XLEN-1:0] right_res;
   logic [XLEN-1:0] s1_result;
   logic            unused_b;

   assign unused_b  = ^in_b[XLEN-1:SHW];
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Decode and mask the shift amount at issue so S1 holds only what the
   // shifter needs.
   always_comb begin
      dec_op    = OP_ILL;
      dec_shamt = in_b[SHW-1:0];
      if (in_funct3 == F3_SLL && !in_funct7b5)
         dec_op = OP_SLL;
      else if (in_funct3 == F3_SR)
         dec_op = in_funct7b5 ? OP_SRA : OP_SRL;
`ifdef SHIFT_EXEC_WORD_OPS_EN
      if (in_word)
         dec_shamt = in_b[SHW-1:0] & WORD_MASK;
`else
      if (in_word)
         dec_op = OP_ILL;
`endif
   end

`ifdef SHIFT_EXEC_WORD_OPS_EN
   logic s1_word;

   shift_word_adjust #(.XLEN(XLEN)) u_word (
      .word    (s1_word),
      .sra     (s1_op == OP_SRA),
      .a       (s1_a),
      .operand (sh_in),
      .raw     (sh_raw),
      .result  (sh_out)
   );
`else
   assign sh_in  = s1_a;
   assign sh_out = sh_raw;
`endif

   Shift #(.XLEN(XLEN), .LEFT(1'b1)) u_left (
      .a      (sh_in),
      .shamt  (s1_shamt),
      .arith  (1'b0),
      .result (left_res)
   );

   Shift #(.XLEN(XLEN), .LEFT(1'b0)) u_right (
      .a      (sh_in),
      .shamt  (s1_shamt),
      .arith  (s1_op == OP_SRA),
      .result (right_res)
   );

   assign sh_raw    = (s1_op == OP_SLL) ? left_res : right_res;
   assign s1_result = (s1_op == OP_ILL) ? '0 : sh_out;

   // Flush wins over everything; otherwise each stage loads when the stage
   // downstream of it is free or draining this cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid    <= 1'b0;
         s2_valid    <= 1'b0;
         s1_op       <= OP_SLL;
         s1_a        <= '0;
         s1_shamt    <= '0;
         s1_tag      <= '0;
`ifdef SHIFT_EXEC_WORD_OPS_EN
         s1_word     <= 1'b0;
`endif
         out_result  <= '0;
         out_tag     <= '0;
         out_illegal <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_op    <= dec_op;
               s1_a     <= in_a;
               s1_shamt <= dec_shamt;
               s1_tag   <= in_tag;
`ifdef SHIFT_EXEC_WORD_OPS_EN
               s1_word  <= in_word;
`endif
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               out_result  <= s1_result;
               out_tag     <= s1_tag;
               out_illegal <= (s1_op == OP_ILL);
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus randomized
// traffic scored against an arithmetic reference model and an in-flight queue.
module tb_shift_exec_stage;
   import shift_exec_pkg::*;

`ifdef SHIFT_EXEC_WORD_OPS_EN
   localparam int XLEN    = 64;
   localparam bit WORD_EN = 1'b1;
`else
   localparam int XLEN    = 32;
   localparam bit WORD_EN = 1'b0;
`endif
   localparam int TAG_W = 5;

   localparam logic [XLEN-1:0] MSB  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] TOP5 = {5'b11111, {(XLEN-5){1'b0}}};
   localparam logic [XLEN-1:0] TOPF = {4'hF, {(XLEN-4){1'b0}}};

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_funct3;
   logic             in_funct7b5;
   logic             in_word;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_illegal;

   typedef struct {
      logic [XLEN-1:0]  result;
      logic [TAG_W-1:0] tag;
      logic             illegal;
      int               acc;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   edges = 0;

   shift_exec_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_funct3   (in_funct3),
      .in_funct7b5 (in_funct7b5),
      .in_word     (in_word),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_tag      (in_tag),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_tag     (out_tag),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) edges++;

   // Reference: {illegal, result} straight from the ISA shift rules.
   function automatic logic [XLEN:0] model(input logic [2:0] f3, input logic f7,
                                           input logic w, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic            ok;
      int unsigned     sh;
      logic [31:0]     lo;
      logic [31:0]     r32;
      logic [XLEN-1:0] res;
      ok = (f3 == 3'b001 && !f7) || (f3 == 3'b101);
      if (w && !WORD_EN)
         ok = 1'b0;
      if (!ok)
         return {1'b1, {XLEN{1'b0}}};
      if (w) begin
         sh = int'(b % 32);
         lo = a[31:0];
         if (f3 == 3'b001)
            r32 = lo << sh;
         else if (f7)
            r32 = $signed(lo) >>> sh;
         else
            r32 = lo >> sh;
         res = XLEN'($signed(r32));
      end else begin
         sh = int'(b % XLEN);
         if (f3 == 3'b001)
            res = a << sh;
         else if (f7)
            res = $signed(a) >>> sh;
         else
            res = a >> sh;
      end
      return {1'b0, res};
   endfunction

   function automatic logic [XLEN-1:0] rnd();
      logic [XLEN-1:0] r;
      for (int i = 0; i < XLEN; i += 32)
         r[i+:32] = $urandom;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [XLEN-1:0] act,
                              input logic [XLEN-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic f7,
                                input logic w, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
      in_valid    = v;
      in_funct3   = f3;
      in_funct7b5 = f7;
      in_word     = w;
      in_a        = a;
      in_b        = b;
      in_tag      = tag;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Every cycle: compare outputs against the oldest outstanding entry, then
   // account for the handshakes the coming edge will perform.
   always begin : compare
      logic            exp_valid;
      logic            exp_ready;
      logic [XLEN:0]   m;
      exp_t            e;
      @(negedge clk);
      #2;
      if (rst_n) begin
         exp_valid = 1'b0;
         if (q.size() > 0)
            exp_valid = (edges - q[0].acc) >= 1;
         exp_ready = !(q.size() >= 2 && !out_ready);
         checkOutput("cyc_out_valid", XLEN'(out_valid), XLEN'(exp_valid));
         checkOutput("cyc_in_ready", XLEN'(in_ready), XLEN'(exp_ready));
         if (exp_valid) begin
            checkOutput("cyc_result", out_result, q[0].result);
            checkOutput("cyc_tag", XLEN'(out_tag), XLEN'(q[0].tag));
            checkOutput("cyc_illegal", XLEN'(out_illegal), XLEN'(q[0].illegal));
         end
         if (flush) begin
            q.delete();
         end else begin
            if (exp_valid && out_ready)
               void'(q.pop_front());
            if (in_valid && exp_ready) begin
               m         = model(in_funct3, in_funct7b5, in_word, in_a, in_b);
               e.result  = m[XLEN-1:0];
               e.illegal = m[XLEN];
               e.tag     = in_tag;
               e.acc     = edges + 1;
               q.push_back(e);
            end
         end
      end
   end

   initial begin : main
      logic [XLEN:0] m;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      idle();

      // Hand-computed anchors for the model itself.
      m = model(F3_SR, 1'b1, 1'b0, MSB, XLEN'(4));
      checkOutput("model_sra", m[XLEN-1:0], TOP5);
      m = model(F3_SLL, 1'b0, 1'b0, XLEN'(1), XLEN'(XLEN + 5));
      checkOutput("model_sll_mask", m[XLEN-1:0], XLEN'(32'h20));
      m = model(F3_SR, 1'b0, 1'b0, TOPF, XLEN'(XLEN - 4));
      checkOutput("model_srl", m[XLEN-1:0], XLEN'(32'hF));
      m = model(3'b000, 1'b0, 1'b0, XLEN'(5), XLEN'(1));
      checkOutput("model_ill_f3", XLEN'(m[XLEN]), XLEN'(1));
      m = model(F3_SLL, 1'b1, 1'b0, XLEN'(5), XLEN'(1));
      checkOutput("model_ill_f7", XLEN'(m[XLEN]), XLEN'(1));

      repeat (2) tick();
      #1;
      checkOutput("rst_out_valid", XLEN'(out_valid), XLEN'(0));
      checkOutput("rst_out_result", out_result, XLEN'(0));
      checkOutput("rst_out_tag", XLEN'(out_tag), XLEN'(0));
      checkOutput("rst_out_illegal", XLEN'(out_illegal), XLEN'(0));
      rst_n = 1'b1;
      checkOutput("rst_in_ready", XLEN'(in_ready), XLEN'(1));

      // SRA of the sign bit, two edges of latency.
      tick();
      applyStimulus(1'b1, F3_SR, 1'b1, 1'b0, MSB, XLEN'(4), 5'd7);
      tick();
      idle();
      tick();
      #1;
      checkOutput("sra_valid", XLEN'(out_valid), XLEN'(1));
      checkOutput("sra_result", out_result, TOP5);
      checkOutput("sra_illegal", XLEN'(out_illegal), XLEN'(0));
      checkOutput("sra_tag", XLEN'(out_tag), XLEN'(7));

      // Back-to-back SLL (masked amount) then SRL, one result per cycle.
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(1), XLEN'(XLEN + 5), 5'd1);
      tick();
      applyStimulus(1'b1, F3_SR, 1'b0, 1'b0, TOPF, XLEN'(XLEN - 4), 5'd2);
      tick();
      idle();
      #1;
      checkOutput("b2b_first", out_result, XLEN'(32'h20));
      checkOutput("b2b_first_tag", XLEN'(out_tag), XLEN'(1));
      tick();
      #1;
      checkOutput("b2b_second_valid", XLEN'(out_valid), XLEN'(1));
      checkOutput("b2b_second", out_result, XLEN'(32'hF));
      checkOutput("b2b_second_tag", XLEN'(out_tag), XLEN'(2));

      // Backpressure: three uops, only two fit while out_ready is low.
      tick();
      out_ready = 1'b0;
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(1), XLEN'(1), 5'd1);
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(1), XLEN'(2), 5'd2);
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(1), XLEN'(3), 5'd3);
      #1;
      checkOutput("bp_in_ready_low", XLEN'(in_ready), XLEN'(0));
      checkOutput("bp_hold_tag", XLEN'(out_tag), XLEN'(1));
      checkOutput("bp_hold_result", out_result, XLEN'(2));
      tick();
      #1;
      checkOutput("bp_hold_result2", out_result, XLEN'(2));
      tick();
      out_ready = 1'b1;
      #1;
      checkOutput("bp_hold_result3", out_result, XLEN'(2));
      checkOutput("bp_in_ready_release", XLEN'(in_ready), XLEN'(1));
      tick();
      idle();
      #1;
      checkOutput("bp_order_tag2", XLEN'(out_tag), XLEN'(2));
      checkOutput("bp_order_res2", out_result, XLEN'(4));
      tick();
      #1;
      checkOutput("bp_order_tag3", XLEN'(out_tag), XLEN'(3));
      checkOutput("bp_order_res3", out_result, XLEN'(8));
      tick();
      #1;
      checkOutput("bp_drained", XLEN'(out_valid), XLEN'(0));

      // SRAW: supported only with word ops built in.
      tick();
      applyStimulus(1'b1, F3_SR, 1'b1, 1'b1, XLEN'(32'h8000_0000), XLEN'(1), 5'd9);
      tick();
      idle();
      tick();
      #1;
`ifdef SHIFT_EXEC_WORD_OPS_EN
      checkOutput("sraw_result", out_result, XLEN'(64'hFFFF_FFFF_C000_0000));
      checkOutput("sraw_illegal", XLEN'(out_illegal), XLEN'(0));
`else
      checkOutput("sraw_result", out_result, XLEN'(0));
      checkOutput("sraw_illegal", XLEN'(out_illegal), XLEN'(1));
`endif
      checkOutput("sraw_tag", XLEN'(out_tag), XLEN'(9));

      // Illegal funct3 still carries its tag.
      tick();
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0, rnd(), rnd(), 5'd21);
      tick();
      idle();
      tick();
      #1;
      checkOutput("ill_flag", XLEN'(out_illegal), XLEN'(1));
      checkOutput("ill_result", out_result, XLEN'(0));
      checkOutput("ill_tag", XLEN'(out_tag), XLEN'(21));

      // Flush with both stages full and a new uop presented.
      tick();
      out_ready = 1'b0;
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(3), XLEN'(1), 5'd11);
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(3), XLEN'(2), 5'd12);
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(3), XLEN'(3), 5'd13);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b1;
      idle();
      #1;
      checkOutput("flush_full_valid", XLEN'(out_valid), XLEN'(0));

      // Flush drops an input even though in_ready is high.
      tick();
      applyStimulus(1'b1, F3_SLL, 1'b0, 1'b0, XLEN'(3), XLEN'(1), 5'd14);
      flush = 1'b1;
      #1;
      checkOutput("flush_in_ready", XLEN'(in_ready), XLEN'(1));
      tick();
      flush = 1'b0;
      idle();
      repeat (2) tick();
      #1;
      checkOutput("flush_drop_valid", XLEN'(out_valid), XLEN'(0));

      // Asynchronous reset in the middle of a cycle with the pipe loaded.
      tick();
      out_ready = 1'b0;
      applyStimulus(1'b1, F3_SR, 1'b1, 1'b0, MSB, XLEN'(2), 5'd15);
      tick();
      applyStimulus(1'b1, F3_SR, 1'b1, 1'b0, MSB, XLEN'(3), 5'd16);
      tick();
      idle();
      #3;
      rst_n = 1'b0;
      #1;
      q.delete();
      checkOutput("arst_valid", XLEN'(out_valid), XLEN'(0));
      checkOutput("arst_result", out_result, XLEN'(0));
      checkOutput("arst_tag", XLEN'(out_tag), XLEN'(0));
      checkOutput("arst_illegal", XLEN'(out_illegal), XLEN'(0));
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      checkOutput("arst_in_ready", XLEN'(in_ready), XLEN'(1));

      // Randomized traffic with random backpressure and occasional flush.
      for (int i = 0; i < 600; i++) begin
         tick();
         applyStimulus($urandom_range(0, 9) < 7,
                       ($urandom_range(0, 4) == 0) ? 3'($urandom) :
                       ($urandom_range(0, 1) == 0) ? F3_SLL : F3_SR,
                       1'($urandom), ($urandom_range(0, 3) == 0),
                       rnd(), rnd(), TAG_W'($urandom));
         out_ready = $urandom_range(0, 9) < 7;
         flush     = $urandom_range(0, 31) == 0;
      end

      tick();
      flush     = 1'b0;
      out_ready = 1'b1;
      idle();
      for (int i = 0; i < 10 && q.size() > 0; i++)
         tick();
      checkOutput("drain_empty", XLEN'(q.size()), XLEN'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
